ifft8: RTL and testbench
========================

Name: ifft8

Overview:
- 8-point radix-2 decimation-in-time inverse FFT. It is the inverse-direction companion of the fft block and uses the same write/start/ready interface and 16-bit signed complex ports.
- Converts frequency-domain bins X[0..7] back to time samples x[0..7], including the 1/8 normalisation.
- Iterative datapath: one shared complex butterfly, 3 stages × 4 butterflies, one butterfly per clock.

Parameters:
- DW, 16, data word width (signed two's complement; Q8.8 convention, not interpreted by the block).
- TW, 16, twiddle width; twiddles are Q2.14 (1.0 = 16384, cos45 = 11585).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- write  input  1  load all eight input bins this cycle
- start  input  1  begin transform on its rising edge (low→high, sampled at clk)
- input0_real..input7_real  input  DW each  real part of bin X[k]
- input0_imag..input7_imag  input  DW each  imaginary part of bin X[k]
- output0_real..output7_real  output  DW each  real part of sample x[n], registered
- output0_imag..output7_imag  output  DW each  imaginary part of sample x[n], registered
- ready  output  1  high while outputs hold a valid result

Behaviour:
- Reset (rst=0, async): state=IDLE, all output registers=0, ready=0, working RAM=0, stage/butterfly counters=0, start history=0.
- States: IDLE, RUN, DONE.
- write=1 in IDLE or DONE: load the 8 bins into the working registers in bit-reversed order (0,4,2,6,1,5,3,7). Clears ready; state→IDLE.
- write=1 in RUN: ignored.
- Start detection: start_edge = start & ~start_q, where start_q is the start value from the previous cycle.
- start_edge in IDLE or DONE with write=0 → RUN, stage=0, bfly=0, ready=0.
- start_edge in a cycle with write=1 is ignored. A start held high from that cycle therefore does not trigger; the bench drops write first, then raises start.
- RUN: one butterfly per cycle.
  - stage s∈{0,1,2}, butterfly b∈{0..3}.
  - Pair span = 2^s.
  - Twiddle index = (b mod 2^s)·(4>>s); twiddle W = exp(+j·2π·idx/8), i.e. the conjugate of the forward twiddle.
  - Twiddle ROM (real, imag): 0:(16384,0), 1:(11585,11585), 2:(0,16384), 3:(−11585,11585).
- Butterfly arithmetic:
  - t = W·B with four 32-bit products; each product sum rounds by adding 2^13, then arithmetic-shifts right by 14.
  - A' = (A + t) >>> 1 and B' = (A − t) >>> 1, computed at 18 bits then saturated to DW (max 32767, min −32768).
  - Per-stage 1/2 scaling gives the total 1/8.
- Latency:
  - start_edge sampled at edge E0.
  - Butterflies written at E1..E12.
  - At E13: outputs copied from working registers, ready=1, state=DONE.
- DONE: outputs and ready hold until the next write or start_edge. A start_edge in DONE recomputes on the current working data (results of the previous run). A write first is needed for fresh data.
- start_edge during RUN: ignored.
- Reset mid-RUN: immediate abort to the reset values above.
- Output ports change only at the E13 copy or on reset.

Test Plan:
- Reset → all outputs 0, ready=0. Drive rst=0 mid-RUN (after 5 butterflies) → ready stays 0, outputs 0, state IDLE.
- DC bin: X[0]=2048, all other bins 0, write then start → ready at E13. Every x[n]=256+0j.
- Impulse at X[1]=2048 → x[0]=256, x[1]=181+181j (±1 LSB), x[2]=0+256j, x[4]=−256, x[6]=0−256j.
- Flat spectrum: all X[k]=800+0j → x[0]=800, x[1..7]=0 (±1 LSB).
- Handshake:
  - write and start both high for one cycle, then write low with start held high → no run.
  - start toggled low→high → run.
  - Second start_edge during RUN → no effect, ready still at E13.
  - write during RUN → working data unchanged.
- Saturation: X[0]=32767, X[4]=32767 → no wrap; x[n] alternates ≈8191 / ≈0, with no sign flips.

Source files
------------

// File: rtl/ifft8.sv
// 8-point radix-2 DIT inverse FFT with a single shared complex butterfly.
// Bins load bit-reversed; each stage halves, so results come out scaled by 1/8.
module ifft8 #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic                 start,
  input  logic signed [DW-1:0] input0_real,
  input  logic signed [DW-1:0] input1_real,
  input  logic signed [DW-1:0] input2_real,
  input  logic signed [DW-1:0] input3_real,
  input  logic signed [DW-1:0] input4_real,
  input  logic signed [DW-1:0] input5_real,
  input  logic signed [DW-1:0] input6_real,
  input  logic signed [DW-1:0] input7_real,
  input  logic signed [DW-1:0] input0_imag,
  input  logic signed [DW-1:0] input1_imag,
  input  logic signed [DW-1:0] input2_imag,
  input  logic signed [DW-1:0] input3_imag,
  input  logic signed [DW-1:0] input4_imag,
  input  logic signed [DW-1:0] input5_imag,
  input  logic signed [DW-1:0] input6_imag,
  input  logic signed [DW-1:0] input7_imag,
  output logic signed [DW-1:0] output0_real,
  output logic signed [DW-1:0] output1_real,
  output logic signed [DW-1:0] output2_real,
  output logic signed [DW-1:0] output3_real,
  output logic signed [DW-1:0] output4_real,
  output logic signed [DW-1:0] output5_real,
  output logic signed [DW-1:0] output6_real,
  output logic signed [DW-1:0] output7_real,
  output logic signed [DW-1:0] output0_imag,
  output logic signed [DW-1:0] output1_imag,
  output logic signed [DW-1:0] output2_imag,
  output logic signed [DW-1:0] output3_imag,
  output logic signed [DW-1:0] output4_imag,
  output logic signed [DW-1:0] output5_imag,
  output logic signed [DW-1:0] output6_imag,
  output logic signed [DW-1:0] output7_imag,
  output logic                 ready
);

  localparam int unsigned PW   = DW + TW;
  localparam int unsigned SW   = PW + 1;
  localparam int unsigned AW   = DW + 2;
  localparam int unsigned FRAC = TW - 2;

  localparam logic signed [TW-1:0] TW_ONE  = TW'(16384);
  localparam logic signed [TW-1:0] TW_C45  = TW'(11585);
  localparam logic signed [SW-1:0] RND     = SW'(1 << (FRAC - 1));
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic                 start_q;
  logic [1:0]           stage_q, stage_d;
  logic [1:0]           bfly_q, bfly_d;
  logic                 ready_q, ready_d;
  logic signed [DW-1:0] wr_q [8];
  logic signed [DW-1:0] wi_q [8];
  logic signed [DW-1:0] wr_d [8];
  logic signed [DW-1:0] wi_d [8];
  logic signed [DW-1:0] or_q [8];
  logic signed [DW-1:0] oi_q [8];
  logic signed [DW-1:0] or_d [8];
  logic signed [DW-1:0] oi_d [8];
  logic signed [DW-1:0] in_r_c [8];
  logic signed [DW-1:0] in_i_c [8];

  logic                 start_edge_c, load_c, go_c;
  logic [2:0]           a_idx_c, b_idx_c;
  logic [1:0]           tw_idx_c;
  logic signed [TW-1:0] tw_r_c, tw_i_c;
  logic signed [DW-1:0] a_r_c, a_i_c, b_r_c, b_i_c;
  logic signed [PW-1:0] p_rr_c, p_ii_c, p_ri_c, p_ir_c;
  logic signed [SW-1:0] sum_r_c, sum_i_c;
  logic signed [AW-1:0] t_r_c, t_i_c, ap_r_c, ap_i_c, am_r_c, am_i_c;
  logic signed [DW-1:0] na_r_c, na_i_c, nb_r_c, nb_i_c;

  function automatic logic [2:0] bitrev3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] x);
    if (x > SAT_MAX)      return DW'(SAT_MAX);
    else if (x < SAT_MIN) return DW'(SAT_MIN);
    else                  return DW'(x);
  endfunction

  assign in_r_c = '{input0_real, input1_real, input2_real, input3_real,
                    input4_real, input5_real, input6_real, input7_real};
  assign in_i_c = '{input0_imag, input1_imag, input2_imag, input3_imag,
                    input4_imag, input5_imag, input6_imag, input7_imag};

  assign start_edge_c = start & ~start_q;
  assign load_c       = write && (state_q != RUN);
  assign go_c         = start_edge_c && !write && (state_q != RUN);

  // Butterfly pair addresses and twiddle index for the current stage/butterfly
  always_comb begin
    a_idx_c  = '0;
    tw_idx_c = '0;
    case (stage_q)
      2'd0: a_idx_c = {bfly_q, 1'b0};
      2'd1: begin
        a_idx_c  = {bfly_q[1], 1'b0, bfly_q[0]};
        tw_idx_c = {bfly_q[0], 1'b0};
      end
      2'd2: begin
        a_idx_c  = {1'b0, bfly_q};
        tw_idx_c = bfly_q;
      end
      default: ;
    endcase
  end

  assign b_idx_c = a_idx_c | (3'd1 << stage_q);

  // Conjugate (inverse-direction) twiddles, Q2.14
  always_comb begin
    tw_r_c = TW_ONE;
    tw_i_c = '0;
    case (tw_idx_c)
      2'd1: begin tw_r_c = TW_C45;  tw_i_c = TW_C45; end
      2'd2: begin tw_r_c = '0;      tw_i_c = TW_ONE; end
      2'd3: begin tw_r_c = -TW_C45; tw_i_c = TW_C45; end
      default: ;
    endcase
  end

  assign a_r_c  = wr_q[a_idx_c];
  assign a_i_c  = wi_q[a_idx_c];
  assign b_r_c  = wr_q[b_idx_c];
  assign b_i_c  = wi_q[b_idx_c];
  assign p_rr_c = PW'(tw_r_c) * PW'(b_r_c);
  assign p_ii_c = PW'(tw_i_c) * PW'(b_i_c);
  assign p_ri_c = PW'(tw_r_c) * PW'(b_i_c);
  assign p_ir_c = PW'(tw_i_c) * PW'(b_r_c);
  assign sum_r_c = SW'(p_rr_c) - SW'(p_ii_c) + RND;
  assign sum_i_c = SW'(p_ri_c) + SW'(p_ir_c) + RND;
  assign t_r_c  = AW'(sum_r_c >>> FRAC);
  assign t_i_c  = AW'(sum_i_c >>> FRAC);
  assign ap_r_c = AW'(a_r_c) + t_r_c;
  assign ap_i_c = AW'(a_i_c) + t_i_c;
  assign am_r_c = AW'(a_r_c) - t_r_c;
  assign am_i_c = AW'(a_i_c) - t_i_c;
  assign na_r_c = sat(ap_r_c >>> 1);
  assign na_i_c = sat(ap_i_c >>> 1);
  assign nb_r_c = sat(am_r_c >>> 1);
  assign nb_i_c = sat(am_i_c >>> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_c)    state_d = IDLE;
        else if (go_c) state_d = RUN;
      end
      RUN:     if (stage_q == 2'd3) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Working-RAM, counter and output-register next values
  always_comb begin
    wr_d    = wr_q;
    wi_d    = wi_q;
    or_d    = or_q;
    oi_d    = oi_q;
    ready_d = ready_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    if (load_c) begin
      for (int i = 0; i < 8; i++) begin
        wr_d[i] = in_r_c[bitrev3(3'(i))];
        wi_d[i] = in_i_c[bitrev3(3'(i))];
      end
      ready_d = 1'b0;
    end else if (go_c) begin
      stage_d = '0;
      bfly_d  = '0;
      ready_d = 1'b0;
    end else if (state_q == RUN) begin
      if (stage_q == 2'd3) begin
        or_d    = wr_q;
        oi_d    = wi_q;
        ready_d = 1'b1;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (3'(i) == a_idx_c) begin
            wr_d[i] = na_r_c;
            wi_d[i] = na_i_c;
          end
          if (3'(i) == b_idx_c) begin
            wr_d[i] = nb_r_c;
            wi_d[i] = nb_i_c;
          end
        end
        bfly_d = bfly_q + 2'd1;
        if (bfly_q == 2'd3) stage_d = stage_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      stage_q <= '0;
      bfly_q  <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wr_q[i] <= '0;
        wi_q[i] <= '0;
        or_q[i] <= '0;
        oi_q[i] <= '0;
      end
    end else begin
      start_q <= start;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      wi_q    <= wi_d;
      or_q    <= or_d;
      oi_q    <= oi_d;
    end
  end

  assign ready        = ready_q;
  assign output0_real = or_q[0];
  assign output1_real = or_q[1];
  assign output2_real = or_q[2];
  assign output3_real = or_q[3];
  assign output4_real = or_q[4];
  assign output5_real = or_q[5];
  assign output6_real = or_q[6];
  assign output7_real = or_q[7];
  assign output0_imag = oi_q[0];
  assign output1_imag = oi_q[1];
  assign output2_imag = oi_q[2];
  assign output3_imag = oi_q[3];
  assign output4_imag = oi_q[4];
  assign output5_imag = oi_q[5];
  assign output6_imag = oi_q[6];
  assign output7_imag = oi_q[7];

endmodule

// File: tb/tb_ifft8.sv
// Directed-vector bench for ifft8: reset, DC/impulse/flat spectra, recompute,
// start/write handshake corner cases, large inputs and reset during a run.
module tb_ifft8;

  logic clk = 1'b0;
  logic rst, write, start;
  logic signed [15:0] in_re [8];
  logic signed [15:0] in_im [8];
  logic signed [15:0] out_re [8];
  logic signed [15:0] out_im [8];
  logic ready;
  int   ex_re [8];
  int   ex_im [8];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ifft8 dut (
    .clk(clk), .rst(rst), .write(write), .start(start),
    .input0_real(in_re[0]), .input1_real(in_re[1]), .input2_real(in_re[2]), .input3_real(in_re[3]),
    .input4_real(in_re[4]), .input5_real(in_re[5]), .input6_real(in_re[6]), .input7_real(in_re[7]),
    .input0_imag(in_im[0]), .input1_imag(in_im[1]), .input2_imag(in_im[2]), .input3_imag(in_im[3]),
    .input4_imag(in_im[4]), .input5_imag(in_im[5]), .input6_imag(in_im[6]), .input7_imag(in_im[7]),
    .output0_real(out_re[0]), .output1_real(out_re[1]), .output2_real(out_re[2]), .output3_real(out_re[3]),
    .output4_real(out_re[4]), .output5_real(out_re[5]), .output6_real(out_re[6]), .output7_real(out_re[7]),
    .output0_imag(out_im[0]), .output1_imag(out_im[1]), .output2_imag(out_im[2]), .output3_imag(out_im[3]),
    .output4_imag(out_im[4]), .output5_imag(out_im[5]), .output6_imag(out_im[6]), .output7_imag(out_im[7]),
    .ready(ready)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_x%0d_re", tag, i), int'(out_re[i]), ex_re[i]);
      check($sformatf("%s_x%0d_im", tag, i), int'(out_im[i]), ex_im[i]);
    end
  endtask

  task automatic clear_bins();
    for (int i = 0; i < 8; i++) begin
      in_re[i] = '0;
      in_im[i] = '0;
    end
  endtask

  task automatic do_write();
    @(negedge clk); write = 1'b1;
    @(negedge clk); write = 1'b0;
  endtask

  // Raise start, then check ready is low after E12 and high after E13
  task automatic do_run(input string tag);
    @(negedge clk); start = 1'b1;
    repeat (13) @(negedge clk);
    check({tag, "_ready_e12"}, int'(ready), 0);
    @(negedge clk);
    check({tag, "_ready_e13"}, int'(ready), 1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; write = 1'b0; start = 1'b0;
    clear_bins();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin ex_re[i] = 0; ex_im[i] = 0; end
    check("rst_ready", int'(ready), 0);
    check_outs("rst");
    rst = 1'b1;
    @(negedge clk);

    // DC bin
    clear_bins(); in_re[0] = 16'sd2048;
    do_write();
    do_run("dc");
    for (int i = 0; i < 8; i++) begin ex_re[i] = 256; ex_im[i] = 0; end
    check_outs("dc");

    // Recompute in DONE on previous results (all 256)
    do_run("recomp");
    for (int i = 0; i < 8; i++) begin ex_re[i] = 0; ex_im[i] = 0; end
    ex_re[0] = 256;
    check_outs("recomp");

    // Impulse at X[1]
    clear_bins(); in_re[1] = 16'sd2048;
    do_write();
    do_run("imp");
    ex_re = '{256, 181, 0, -181, -256, -181, 0, 181};
    ex_im = '{0, 181, 256, 181, 0, -181, -256, -181};
    check_outs("imp");

    // Flat spectrum
    for (int i = 0; i < 8; i++) begin in_re[i] = 16'sd800; in_im[i] = '0; end
    do_write();
    do_run("flat");
    for (int i = 0; i < 8; i++) begin ex_re[i] = 0; ex_im[i] = 0; end
    ex_re[0] = 800;
    check_outs("flat");

    // write and start together, start held: no run
    clear_bins(); in_re[0] = 16'sd2048;
    @(negedge clk); write = 1'b1; start = 1'b1;
    @(negedge clk); write = 1'b0;
    repeat (20) @(negedge clk);
    check("hs_norun_ready", int'(ready), 0);
    check("hs_norun_hold", int'(out_re[0]), 800);

    // Proper edge; extra edge and a write during RUN must both be ignored
    start = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      case (c)
        3: start = 1'b0;
        4: start = 1'b1;
        5: begin clear_bins(); in_re[1] = 16'sd2048; write = 1'b1; end
        6: write = 1'b0;
        13: check("hs_ready_e12", int'(ready), 0);
        14: check("hs_ready_e13", int'(ready), 1);
        default: ;
      endcase
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin ex_re[i] = 256; ex_im[i] = 0; end
    check_outs("hs");

    // Large inputs: no wrap, alternating ~8191 / 0
    clear_bins(); in_re[0] = 16'sd32767; in_re[4] = 16'sd32767;
    do_write();
    do_run("sat");
    ex_re = '{8191, 0, 8191, 0, 8191, 0, 8191, 0};
    for (int i = 0; i < 8; i++) ex_im[i] = 0;
    check_outs("sat");

    // Reset after five butterflies of a recompute
    @(negedge clk); start = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin ex_re[i] = 0; ex_im[i] = 0; end
    check("midrst_ready", int'(ready), 0);
    check_outs("midrst");
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (16) @(negedge clk);
    check("midrst_idle_ready", int'(ready), 0);
    check("midrst_idle_x0", int'(out_re[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
